// File: rtl/cg_enable_ctrl.sv
// cg_enable_ctrl
//
// Always-on idle-detect controller that produces the enable for the
// cgcontrol clock-gating cell. It counts consecutive idle cycles of the
// downstream domain. It then requests sleep with a req/ack handshake and
// drops the gate enable once the request is acknowledged. On wake or force
// it restores the clock, and raises ready_o after a fixed settle time.
//
// Optional feature macro: CG_STATS_EN
//   defined   -> gated_cycles_o counts edges with cg_en_o low (saturating)
//   undefined -> gated_cycles_o is tied to zero
//
// Handshake semantics (sleep_req_o / sleep_ack_i):
//   sleep_req_o rises when the controller wants to gate and stays high
//   through DRAIN and GATED. The downstream raises sleep_ack_i once it has
//   quiesced. In DRAIN, a sampled ack with no competing activity, wake or
//   force moves the FSM to GATED. Any non-idle sample in DRAIN withdraws
//   the request, and this abort wins over a same-cycle ack. After wake the
//   request drops, and ready_o is withheld until the downstream has
//   released sleep_ack_i.
//
// Every output comes straight from a flop. cg_en_o therefore changes only
// on a rising clk edge and stays stable through the low phase that the
// cgcontrol latch is transparent in.

module cg_enable_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              activity_i,
    input  logic              wake_i,
    input  logic              force_on_i,
    input  logic              sleep_ack_i,
    output logic              sleep_req_o,
    output logic              cg_en_o,
    output logic              ready_o,
    output logic [1:0]        state_o,
    output logic [STAT_W-1:0] gated_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    // Terminal counter values, sized once so the compares match in width.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic             cg_en_q, cg_en_d;
    logic             ready_q, ready_d;
    logic             sleep_req_q, sleep_req_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;

    // An idle sample has no activity, no wake request and no debug force.
    logic idle_sample;
    assign idle_sample = ~activity_i & ~wake_i & ~force_on_i;

    // Next-state and registered-output logic of the gating FSM.
    always_comb begin
        state_d     = state_q;
        cg_en_d     = cg_en_q;
        ready_d     = ready_q;
        sleep_req_d = sleep_req_q;
        idle_cnt_d  = idle_cnt_q;
        wake_cnt_d  = wake_cnt_q;

        unique case (state_q)
            ST_RUN: begin
                cg_en_d     = 1'b1;
                ready_d     = 1'b1;
                sleep_req_d = 1'b0;
                if (idle_sample) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        // Enough consecutive idle samples: ask to sleep.
                        state_d     = ST_DRAIN;
                        sleep_req_d = 1'b1;
                        ready_d     = 1'b0;
                        idle_cnt_d  = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_ONE;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end

            ST_DRAIN: begin
                cg_en_d     = 1'b1;
                sleep_req_d = 1'b1;
                ready_d     = 1'b0;
                if (!idle_sample) begin
                    // Abort has priority over a coincident acknowledge.
                    state_d     = ST_RUN;
                    sleep_req_d = 1'b0;
                    ready_d     = 1'b1;
                    idle_cnt_d  = '0;
                end else if (sleep_ack_i) begin
                    state_d = ST_GATED;
                    cg_en_d = 1'b0;
                end
            end

            ST_GATED: begin
                // activity_i comes from the stopped domain, so it is ignored.
                cg_en_d     = 1'b0;
                sleep_req_d = 1'b1;
                ready_d     = 1'b0;
                if (wake_i || force_on_i) begin
                    state_d     = ST_WAKE;
                    cg_en_d     = 1'b1;
                    sleep_req_d = 1'b0;
                    wake_cnt_d  = WAKE_LAST;
                end
            end

            ST_WAKE: begin
                cg_en_d     = 1'b1;
                sleep_req_d = 1'b0;
                ready_d     = 1'b0;
                if (wake_cnt_q != '0) begin
                    wake_cnt_d = wake_cnt_q - CNT_ONE;
                end else if (!sleep_ack_i) begin
                    // Clock has settled and the downstream released its ack.
                    state_d    = ST_RUN;
                    ready_d    = 1'b1;
                    idle_cnt_d = '0;
                end
            end

            default: begin
                state_d     = ST_RUN;
                cg_en_d     = 1'b1;
                ready_d     = 1'b1;
                sleep_req_d = 1'b0;
                idle_cnt_d  = '0;
                wake_cnt_d  = '0;
            end
        endcase
    end

    // State and output registers. Reset forces the clock on from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cg_en_q     <= 1'b1;
            ready_q     <= 1'b1;
            sleep_req_q <= 1'b0;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cg_en_q     <= cg_en_d;
            ready_q     <= ready_d;
            sleep_req_q <= sleep_req_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
        end
    end

    assign cg_en_o     = cg_en_q;
    assign ready_o     = ready_q;
    assign sleep_req_o = sleep_req_q;
    assign state_o     = state_q;

`ifdef CG_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [STAT_W-1:0] gated_q, gated_d;

    // Saturating count of edges that see the gate enable low.
    always_comb begin
        gated_d = gated_q;
        if (!cg_en_q && (gated_q != '1)) begin
            gated_d = gated_q + STAT_ONE;
        end
    end

    // Statistic register; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_q <= '0;
        end else begin
            gated_q <= gated_d;
        end
    end

    assign gated_cycles_o = gated_q;
`else
    assign gated_cycles_o = '0;
`endif

endmodule

// File: doc/cg_enable_ctrl.md
# cg_enable_ctrl

Idle-detect controller that generates the enable for the `cgcontrol` clock-gating cell. It watches activity from the downstream domain and requests a sleep with a req/ack handshake. After acknowledge it drops the gate enable. On wake or force it restores the clock and signals readiness after a fixed settle time. It sits in the always-on domain, and `cg_en_o` drives the `en` input of `cgcontrol` directly.

## Interface
- `IDLE_CYCLES`, 16: consecutive idle cycles before a sleep request; must be ≥1.
- `WAKE_CYCLES`, 2: cycles from re-enable to `ready_o`; must be ≥1.
- `CNT_W`, 8: width of the idle and wake counters; must hold `max(IDLE_CYCLES, WAKE_CYCLES)`.
- `STAT_W`, 32: width of the gated-cycle statistic.
- `clk` in 1: free-running always-on clock (the same clock fed to `cgcontrol`).
- `rst_n` in 1: reset, asynchronous, active-low.
- `activity_i` in 1: downstream busy; high means do not gate.
- `wake_i` in 1: wake request, level-sensitive.
- `force_on_i` in 1: debug override; keeps or brings the clock on.
- `sleep_ack_i` in 1: downstream has quiesced and accepts the gating.
- `sleep_req_o` out 1: sleep request to downstream.
- `cg_en_o` out 1: gate enable to `cgcontrol.en`.
- `ready_o` out 1: downstream clock running and settled.
- `state_o` out 2: current state (RUN=0, DRAIN=1, GATED=2, WAKE=3).
- `gated_cycles_o` out STAT_W: count of cycles with `cg_en_o`=0 (see Configuration).

## Operation
- All outputs are registered.
- Reset values: state RUN, `cg_en_o`=1, `ready_o`=1, `sleep_req_o`=0, `state_o`=0, idle and wake counters 0, `gated_cycles_o`=0.
- An "idle sample" means `activity_i`=0, `wake_i`=0 and `force_on_i`=0 on a rising edge.
- **RUN**
  - Each idle sample increments `idle_cnt`; any non-idle sample clears it.
  - When an idle sample arrives with `idle_cnt`==IDLE_CYCLES-1: go to DRAIN, set `sleep_req_o`=1, set `ready_o`=0, clear `idle_cnt`.
- **DRAIN**
  - Hold `sleep_req_o`=1 and `cg_en_o`=1.
  - Any non-idle sample aborts the sleep: go to RUN, `sleep_req_o`=0, `ready_o`=1. Abort takes priority over a same-cycle `sleep_ack_i`.
  - Otherwise, `sleep_ack_i`=1 causes: go to GATED, `cg_en_o`=0.
- **GATED**
  - `cg_en_o`=0, `sleep_req_o`=1, `ready_o`=0.
  - `activity_i` is ignored, because it comes from the gated domain.
  - `wake_i` or `force_on_i` causes: go to WAKE, `cg_en_o`=1, `sleep_req_o`=0, load `wake_cnt`=WAKE_CYCLES-1.
- **WAKE**
  - `cg_en_o`=1, `sleep_req_o`=0.
  - `wake_cnt` decrements to 0 and then holds.
  - When `wake_cnt`==0 and `sleep_ack_i`=0: go to RUN, `ready_o`=1, clear `idle_cnt`.
  - If `sleep_ack_i` stays high, remain in WAKE.
- Reset may assert in any state, including mid-handshake. All state returns asynchronously to the reset values, so the clock is forced on.
- Counters never wrap; each is cleared or reloaded on state entry.

## Timing
- Sleep request: with idle samples starting at edge 0, `sleep_req_o` rises after edge IDLE_CYCLES-1, i.e. after IDLE_CYCLES idle samples.
- Gate-off: `sleep_ack_i` sampled at edge N gives `cg_en_o` low after edge N. The `cgcontrol` latch then suppresses the `gclk` pulse that starts at edge N+1.
- Wake: `wake_i` sampled at edge N gives `cg_en_o` high after edge N, and `ready_o` high after edge N+WAKE_CYCLES (given `sleep_ack_i` low).
- `cg_en_o` changes only on a rising `clk` edge. It is stable through the clock-low phase, so the gate stays glitch-free.

## Configuration
- Macro `CG_STATS_EN`.
- Defined: `gated_cycles_o` increments on every edge where `cg_en_o`=0. It saturates at all-ones, never wraps, and clears only on reset.
- Undefined: the counter logic is omitted, and `gated_cycles_o` is tied to 0 so the port list is unchanged.

## Test plan
- Reset release with `activity_i`=0, IDLE_CYCLES=16: `sleep_req_o` rises after the 16th edge, and `ready_o` falls on the same edge.
- In DRAIN, raise `activity_i` and `sleep_ack_i` together: next state RUN, `sleep_req_o`=0, `cg_en_o` stays 1, `ready_o`=1.
- Complete the handshake (ack at edge N), then `wake_i` at edge N+10 with WAKE_CYCLES=2: `cg_en_o`=0 over edges N+1..N+10, `cg_en_o`=1 after N+10, `ready_o`=1 after N+12.
- In WAKE, hold `sleep_ack_i` high for 5 extra cycles: `ready_o` stays 0 until the edge after ack drops.
- Assert `rst_n` low in GATED mid-cycle: `cg_en_o`=1, `sleep_req_o`=0 and `state_o`=0 immediately, without waiting for a `clk` edge.
- With `CG_STATS_EN`, STAT_W=4, hold GATED for 20 cycles: `gated_cycles_o` saturates at 15. Without the macro it reads 0.
